// File: rtl/lc3_pkg.sv
// Shared LC-3 control definitions: FSM state numbering, opcodes, datapath mux
// encodings and the packed control word consumed by the datapath.
package lc3_pkg;

    // LC-3 state numbers reach 35, so the state register needs six bits
    localparam int unsigned S_W = 6;

    typedef enum logic [S_W-1:0] {
        S0     = 6'd0,
        S1     = 6'd1,
        S2     = 6'd2,
        S3     = 6'd3,
        S4     = 6'd4,
        S5     = 6'd5,
        S6     = 6'd6,
        S7     = 6'd7,
        S9     = 6'd9,
        S12    = 6'd12,
        S14    = 6'd14,
        S15    = 6'd15,
        S16    = 6'd16,
        S18    = 6'd18,
        S20    = 6'd20,
        S21    = 6'd21,
        S22    = 6'd22,
        S23    = 6'd23,
        S25    = 6'd25,
        S27    = 6'd27,
        S28    = 6'd28,
        S30    = 6'd30,
        S32    = 6'd32,
        S33    = 6'd33,
        S35    = 6'd35,
        S_HALT = 6'd63
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RSV  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic [1:0] {PCMUX_INC = 2'b00, PCMUX_BUS = 2'b01, PCMUX_ADDER = 2'b10} pcmux_t;
    typedef enum logic [1:0] {DRMUX_IR119 = 2'b00, DRMUX_R7 = 2'b01, DRMUX_R6 = 2'b10} drmux_t;
    typedef enum logic [1:0] {SR1MUX_IR119 = 2'b00, SR1MUX_IR86 = 2'b01} sr1mux_t;
    typedef enum logic [1:0] {
        A2_ZERO  = 2'b00,
        A2_OFF6  = 2'b01,
        A2_OFF9  = 2'b10,
        A2_OFF11 = 2'b11
    } addr2mux_t;
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_AND   = 2'b01,
        ALU_NOT   = 2'b10,
        ALU_PASSA = 2'b11
    } aluk_t;

    typedef struct packed {
        logic      ld_mar;
        logic      ld_mdr;
        logic      ld_ir;
        logic      ld_pc;
        logic      ld_reg;
        logic      ld_cc;
        logic      gate_pc;
        logic      gate_mdr;
        logic      gate_alu;
        logic      gate_marmux;
        pcmux_t    pcmux;
        drmux_t    drmux;
        sr1mux_t   sr1mux;
        logic      addr1mux;
        addr2mux_t addr2mux;
        logic      marmux;
        aluk_t     aluk;
        logic      mio_en;
        logic      r_w;
        logic      halted;
    } ctrl_t;

endpackage

// File: rtl/lc3_ctrl_decode.sv
// Combinational state -> control word decode for the LC-3 control FSM.
module lc3_ctrl_decode
    import lc3_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_rdy,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S18: begin
                o_ctrl.ld_mar  = 1'b1;
                o_ctrl.ld_pc   = 1'b1;
                o_ctrl.gate_pc = 1'b1;
                o_ctrl.pcmux   = PCMUX_INC;
            end
            S33, S25: begin
                o_ctrl.mio_en = 1'b1;
                o_ctrl.ld_mdr = 1'b1;
            end
            S35: begin
                o_ctrl.gate_mdr = 1'b1;
                o_ctrl.ld_ir    = 1'b1;
            end
            S1, S5, S9: begin
                o_ctrl.sr1mux   = SR1MUX_IR86;
                o_ctrl.ld_reg   = 1'b1;
                o_ctrl.ld_cc    = 1'b1;
                o_ctrl.gate_alu = 1'b1;
                o_ctrl.aluk     = (i_state == S5) ? ALU_AND :
                                  (i_state == S9) ? ALU_NOT : ALU_ADD;
            end
            S14: begin
                o_ctrl.addr2mux    = A2_OFF9;
                o_ctrl.marmux      = 1'b1;
                o_ctrl.gate_marmux = 1'b1;
                o_ctrl.ld_reg      = 1'b1;
            end
            S2, S3: begin
                o_ctrl.addr2mux    = A2_OFF9;
                o_ctrl.marmux      = 1'b1;
                o_ctrl.gate_marmux = 1'b1;
                o_ctrl.ld_mar      = 1'b1;
            end
            // Base+offset still travels through the adder path of MARMUX
            S6, S7: begin
                o_ctrl.addr1mux    = 1'b1;
                o_ctrl.sr1mux      = SR1MUX_IR86;
                o_ctrl.addr2mux    = A2_OFF6;
                o_ctrl.marmux      = 1'b1;
                o_ctrl.gate_marmux = 1'b1;
                o_ctrl.ld_mar      = 1'b1;
            end
            S27: begin
                o_ctrl.gate_mdr = 1'b1;
                o_ctrl.ld_reg   = 1'b1;
                o_ctrl.ld_cc    = 1'b1;
            end
            S23: begin
                o_ctrl.sr1mux   = SR1MUX_IR119;
                o_ctrl.aluk     = ALU_PASSA;
                o_ctrl.gate_alu = 1'b1;
                o_ctrl.ld_mdr   = 1'b1;
            end
            S16: begin
                o_ctrl.mio_en = 1'b1;
                o_ctrl.r_w    = 1'b1;
            end
            S22: begin
                o_ctrl.addr2mux = A2_OFF9;
                o_ctrl.pcmux    = PCMUX_ADDER;
                o_ctrl.ld_pc    = 1'b1;
            end
            S12, S20: begin
                o_ctrl.sr1mux   = SR1MUX_IR86;
                o_ctrl.addr1mux = 1'b1;
                o_ctrl.addr2mux = A2_ZERO;
                o_ctrl.pcmux    = PCMUX_ADDER;
                o_ctrl.ld_pc    = 1'b1;
            end
            S4: begin
                o_ctrl.gate_pc = 1'b1;
                o_ctrl.drmux   = DRMUX_R7;
                o_ctrl.ld_reg  = 1'b1;
            end
            S21: begin
                o_ctrl.addr2mux = A2_OFF11;
                o_ctrl.pcmux    = PCMUX_ADDER;
                o_ctrl.ld_pc    = 1'b1;
            end
            S15: begin
                o_ctrl.marmux      = 1'b0;
                o_ctrl.gate_marmux = 1'b1;
                o_ctrl.ld_mar      = 1'b1;
            end
            // R7 is written once, on the cycle the memory read completes
            S28: begin
                o_ctrl.mio_en  = 1'b1;
                o_ctrl.ld_mdr  = 1'b1;
                o_ctrl.gate_pc = 1'b1;
                o_ctrl.drmux   = DRMUX_R7;
                o_ctrl.ld_reg  = i_mem_rdy;
            end
            S30: begin
                o_ctrl.gate_mdr = 1'b1;
                o_ctrl.pcmux    = PCMUX_BUS;
                o_ctrl.ld_pc    = 1'b1;
            end
            S_HALT: begin
                o_ctrl.halted = 1'b1;
            end
            default: begin
                o_ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// Multi-cycle LC-3 control unit: owns IR and BEN, sequences fetch/decode/execute
// and drives the datapath controls through lc3_ctrl_decode.
module lc3_ctrl_fsm
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] main_bus,
    input  logic [2:0]  nzp,
    input  logic        mem_rdy,
    output logic [15:0] ir,
    output logic [5:0]  ld,
    output logic [3:0]  gate,
    output logic [1:0]  pcmux,
    output logic [1:0]  drmux,
    output logic [1:0]  sr1mux,
    output logic        addr1mux,
    output logic [1:0]  addr2mux,
    output logic        marmux,
    output logic [1:0]  aluk,
    output logic        mio_en,
    output logic        r_w,
    output logic        halted
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;
    logic        r_ben;
    ctrl_t       w_ctrl;
    ctrl_t       w_out;

    lc3_ctrl_decode u_decode (
        .i_state   (r_state),
        .i_mem_rdy (mem_rdy),
        .o_ctrl    (w_ctrl)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S18;
            r_ir    <= '0;
            r_ben   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_ctrl.ld_ir) begin
                r_ir <= main_bus;
            end
            if (r_state == S32) begin
                r_ben <= |(r_ir[11:9] & nzp);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S18: w_next = S33;
            S33: if (mem_rdy) w_next = S35;
            S35: w_next = S32;
            S32: begin
                case (r_ir[15:12])
                    OP_BR:   w_next = S0;
                    OP_ADD:  w_next = S1;
                    OP_LD:   w_next = S2;
                    OP_ST:   w_next = S3;
                    OP_JSR:  w_next = S4;
                    OP_AND:  w_next = S5;
                    OP_LDR:  w_next = S6;
                    OP_STR:  w_next = S7;
                    OP_NOT:  w_next = S9;
                    OP_JMP:  w_next = S12;
                    OP_LEA:  w_next = S14;
                    OP_TRAP: w_next = S15;
                    default: w_next = S_HALT;
                endcase
            end
            S1, S5, S9, S14, S12, S20, S21, S22, S27, S30: w_next = S18;
            S2, S6:  w_next = S25;
            S25:     if (mem_rdy) w_next = S27;
            S3, S7:  w_next = S23;
            S23:     w_next = S16;
            S16:     if (mem_rdy) w_next = S18;
            S0:      w_next = r_ben ? S22 : S18;
            S4:      w_next = r_ir[11] ? S21 : S20;
            S15:     w_next = S28;
            S28:     if (mem_rdy) w_next = S30;
            S_HALT:  w_next = S_HALT;
            default: w_next = S18;
        endcase
    end

    // Every output, IR included, reads as zero while reset is held
    always_comb begin
        w_out = '0;
        if (rst) begin
            w_out = w_ctrl;
        end
    end

    assign ir       = (rst && !w_ctrl.halted) ? r_ir : '0;
    assign ld       = {w_out.ld_mar, w_out.ld_mdr, w_out.ld_ir,
                       w_out.ld_pc, w_out.ld_reg, w_out.ld_cc};
    assign gate     = {w_out.gate_pc, w_out.gate_mdr, w_out.gate_alu, w_out.gate_marmux};
    assign pcmux    = w_out.pcmux;
    assign drmux    = w_out.drmux;
    assign sr1mux   = w_out.sr1mux;
    assign addr1mux = w_out.addr1mux;
    assign addr2mux = w_out.addr2mux;
    assign marmux   = w_out.marmux;
    assign aluk     = w_out.aluk;
    assign mio_en   = w_out.mio_en;
    assign r_w      = w_out.r_w;
    assign halted   = w_out.halted;

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Bench for lc3_ctrl_fsm: per-instruction micro-op sequences checked cycle by cycle.
module tb_lc3_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic [15:0] main_bus;
    logic [2:0]  nzp;
    logic        mem_rdy;
    logic [15:0] ir;
    logic [5:0]  ld;
    logic [3:0]  gate;
    logic [1:0]  pcmux;
    logic [1:0]  drmux;
    logic [1:0]  sr1mux;
    logic        addr1mux;
    logic [1:0]  addr2mux;
    logic        marmux;
    logic [1:0]  aluk;
    logic        mio_en;
    logic        r_w;
    logic        halted;

    lc3_ctrl_fsm dut (
        .clk      (clk),
        .rst      (rst),
        .main_bus (main_bus),
        .nzp      (nzp),
        .mem_rdy  (mem_rdy),
        .ir       (ir),
        .ld       (ld),
        .gate     (gate),
        .pcmux    (pcmux),
        .drmux    (drmux),
        .sr1mux   (sr1mux),
        .addr1mux (addr1mux),
        .addr2mux (addr2mux),
        .marmux   (marmux),
        .aluk     (aluk),
        .mio_en   (mio_en),
        .r_w      (r_w),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] LMAR = 6'b100000, LMDR = 6'b010000, LIR = 6'b001000;
    localparam logic [5:0] LPC  = 6'b000100, LREG = 6'b000010, LCC = 6'b000001;
    localparam logic [3:0] GPC  = 4'b1000, GMDR = 4'b0100, GALU = 4'b0010, GMM = 4'b0001;

    typedef struct {
        logic [24:0] c;
        bit          wt;
        bit          xreg;
        bit          setir;
        bit          halt;
    } step_t;

    step_t       q[$];
    logic [15:0] ir_exp;
    int          n_tests;
    int          n_fail;

    function automatic logic [24:0] mk(input logic [5:0] l, input logic [3:0] g,
                                       input logic [1:0] pm, input logic [1:0] dm,
                                       input logic [1:0] sm, input logic a1,
                                       input logic [1:0] a2, input logic mm,
                                       input logic [1:0] ak, input logic mio,
                                       input logic rw, input logic h);
        return {l, g, pm, dm, sm, a1, a2, mm, ak, mio, rw, h};
    endfunction

    task automatic check(input string tag, input logic [40:0] exp);
        logic [40:0] obs;
        obs = {ir, ld, gate, pcmux, drmux, sr1mux, addr1mux, addr2mux, marmux,
               aluk, mio_en, r_w, halted};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic add(input logic [24:0] c, input bit wt, input bit xreg,
                       input bit setir, input bit halt);
        step_t s;
        s.c = c; s.wt = wt; s.xreg = xreg; s.setir = setir; s.halt = halt;
        q.push_back(s);
    endtask

    // Expected micro-op sequence of one instruction, derived from its opcode.
    task automatic build(input logic [15:0] in, input logic [2:0] cc);
        logic [24:0] jmp_w;
        logic [24:0] addr_w;
        logic [1:0]  ak;
        q.delete();
        add(mk(LMAR | LPC, GPC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
        add(mk(LMDR, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, 0, 0, 0);
        add(mk(LIR, GMDR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0);
        add('0, 0, 0, 0, 0);
        jmp_w  = mk(LPC, 0, 2'b10, 0, 2'b01, 1, 2'b00, 0, 0, 0, 0, 0);
        addr_w = in[14] ? mk(LMAR, GMM, 0, 0, 2'b01, 1, 2'b01, 1, 0, 0, 0, 0)
                        : mk(LMAR, GMM, 0, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 0);
        ak = (in[15:12] == 4'd5) ? 2'b01 : (in[15:12] == 4'd9) ? 2'b10 : 2'b00;
        case (in[15:12])
            4'd0: begin
                add('0, 0, 0, 0, 0);
                if (|(in[11:9] & cc))
                    add(mk(LPC, 0, 2'b10, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0), 0, 0, 0, 0);
            end
            4'd1, 4'd5, 4'd9:
                add(mk(LREG | LCC, GALU, 0, 0, 2'b01, 0, 0, 0, ak, 0, 0, 0), 0, 0, 0, 0);
            4'd2, 4'd6: begin
                add(addr_w, 0, 0, 0, 0);
                add(mk(LMDR, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, 0, 0, 0);
                add(mk(LREG | LCC, GMDR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
            end
            4'd3, 4'd7: begin
                add(addr_w, 0, 0, 0, 0);
                add(mk(LMDR, GALU, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0), 0, 0, 0, 0);
                add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 1, 0, 0, 0);
            end
            4'd4: begin
                add(mk(LREG, GPC, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
                if (in[11])
                    add(mk(LPC, 0, 2'b10, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0), 0, 0, 0, 0);
                else
                    add(jmp_w, 0, 0, 0, 0);
            end
            4'd12: add(jmp_w, 0, 0, 0, 0);
            4'd14: add(mk(LREG, GMM, 0, 0, 0, 0, 2'b10, 1, 0, 0, 0, 0), 0, 0, 0, 0);
            4'd15: begin
                add(mk(LMAR, GMM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
                add(mk(LMDR | LREG, GPC, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0), 1, 1, 0, 0);
                add(mk(LPC, GMDR, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
            end
            default:
                for (int k = 0; k < 6; k++)
                    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 1);
        endcase
    endtask

    // wait_n < 0: random memory latency; abort_step >= 0: stop before that step.
    task automatic run_instr(input logic [15:0] in, input logic [2:0] cc,
                             input int wait_n, input int abort_step);
        logic [24:0] exp_c;
        logic        rdy;
        int          waited;
        build(in, cc);
        for (int i = 0; i < q.size(); i++) begin
            if (i == abort_step) return;
            waited = 0;
            forever begin
                @(negedge clk);
                main_bus = in;
                nzp      = cc;
                if (q[i].wt)
                    rdy = (wait_n >= 0) ? (waited == wait_n)
                                        : (waited >= 3 || $urandom_range(1, 0) == 1);
                else
                    rdy = 1'($urandom_range(1, 0));
                mem_rdy = rdy;
                #1;
                exp_c = q[i].c;
                if (q[i].wt && q[i].xreg && !rdy)
                    exp_c = exp_c & ~mk(LREG, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                check($sformatf("i%h_s%0d_w%0d", in, i, waited),
                      {(q[i].halt ? 16'h0000 : ir_exp), exp_c});
                if (!q[i].wt || rdy) break;
                waited++;
            end
            if (q[i].setir) ir_exp = in;
        end
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst      = 1'b0;
            mem_rdy  = 1'($urandom_range(1, 0));
            main_bus = 16'($urandom);
            #1;
            check($sformatf("reset_c%0d", k), 41'd0);
        end
        @(posedge clk);
        #1;
        rst    = 1'b1;
        ir_exp = '0;
    endtask

    initial begin
        logic [3:0]  ops [12];
        logic [15:0] rin;
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b0;
        main_bus = '0;
        nzp      = '0;
        mem_rdy  = 1'b0;
        ir_exp   = '0;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd12, 4'd14, 4'd15};

        do_reset(2);
        run_instr(16'h1261, 3'b000, 0, -1);
        run_instr(16'h0402, 3'b010, 0, -1);
        run_instr(16'h0402, 3'b100, 0, -1);
        run_instr(16'h3005, 3'b001, 3, -1);
        run_instr(16'hF025, 3'b010, 2, -1);
        run_instr(16'h4800, 3'b000, 1, -1);
        run_instr(16'h4040, 3'b000, 0, -1);
        run_instr(16'h6A7F, 3'b000, 2, -1);
        run_instr(16'h7283, 3'b000, 1, -1);
        run_instr(16'h0E01, 3'b111, 0, -1);

        for (int n = 0; n < 40; n++) begin
            rin = {ops[$urandom_range(11, 0)], 12'($urandom)};
            run_instr(rin, 3'($urandom_range(7, 0)), -1, -1);
        end

        // TRAP interrupted while waiting in the memory read
        run_instr(16'hF025, 3'b000, 5, 5);
        do_reset(2);
        run_instr(16'h5021, 3'b000, 0, -1);
        // Store interrupted while the write is pending
        run_instr(16'h3005, 3'b000, 5, 6);
        do_reset(1);
        run_instr(16'h1261, 3'b000, 0, -1);

        run_instr(16'hD000, 3'b000, 0, -1);
        do_reset(2);
        run_instr(16'h8000, 3'b000, 1, -1);
        do_reset(1);
        run_instr(16'hE1FF, 3'b000, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
